// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   XLEN          address / instruction width
//   INSTR_NOP     canonical RISC-V nop (addi x0, x0, 0)
//   PC_STEP       byte distance between consecutive instruction words
//   fetch_entry_t one prefetch buffer entry: {pc, instr}
//   align_pc      clears the two low address bits (word alignment)
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of fetch_entry_t.
//   clk, rst_n  clock, synchronous active-low reset (clears storage too,
//               so head reads as zero straight after reset)
//   push        write push_entry at the tail
//   push_entry  entry to write
//   pop         drop the head entry (ignored while empty)
//   flush       discard all entries; overrides push and pop
//   count       number of valid entries, 0..DEPTH
//   empty       count == 0
//   head        oldest entry (combinational read)
module riscv_fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [AW:0]  count,
  output logic         empty,
  output fetch_entry_t head
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  fetch_entry_t mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // At full, a simultaneous push overwrites the slot being popped,
      // which is safe because the head is consumed in this same cycle.
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_entry;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(do_push && !do_pop && count == (AW+1)'(DEPTH)))
        else $error("riscv_fetch_fifo: push into full buffer");
    end
  end

endmodule

// File: rtl/riscv_ifetch.sv
// Instruction-fetch front end feeding decode.
// Issues word-aligned IMEM reads, buffers in-order responses in a prefetch
// FIFO and presents {pc, instr} to decode over valid/ready. A redirect
// flushes the buffer and discards every response still in flight.
//   clk, rst_n      clock, synchronous active-low reset
//   imem_req_*      request channel (valid/ready, byte address)
//   imem_rsp_*      in-order response channel (no backpressure)
//   redirect_*      flush and restart fetch at redirect_pc
//   dec_*           decode channel (valid/ready, pc, instr)
module riscv_ifetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_instr
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     committed;
  logic            active;
  logic            fifo_empty;
  logic            req_fire;
  logic            rsp_live;
  logic            rsp_accept;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Buffered entries plus in-flight requests never exceed the buffer size,
  // so every response has a slot reserved and overflow is impossible.
  assign committed      = {1'b0, fifo_count} + {1'b0, outstanding};
  // active keeps the request channel quiet during the first cycle after reset.
  assign imem_req_valid = active && !redirect_valid &&
                          (committed < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is stray and ignored entirely.
  assign rsp_live   = imem_rsp_valid && (outstanding != '0);
  assign rsp_accept = rsp_live && (drop_cnt == '0) && !redirect_valid;

  assign push_entry.pc    = rsp_pc;
  assign push_entry.instr = imem_rsp_data;

  assign dec_valid = !fifo_empty && !redirect_valid;
  assign pop       = dec_valid && dec_ready;
  assign dec_pc    = head.pc;
  assign dec_instr = head.instr;

  riscv_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (rsp_accept),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (fifo_count),
    .empty      (fifo_empty),
    .head       (head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      active      <= 1'b0;
    end else begin
      active <= 1'b1;

      if (req_fire && !rsp_live)      outstanding <= outstanding + 1'b1;
      else if (!req_fire && rsp_live) outstanding <= outstanding - 1'b1;

      if (redirect_valid) begin
        // No request issues in this cycle, so everything still in flight
        // after this edge is stale and must be discarded.
        fetch_pc <= align_pc(redirect_pc);
        rsp_pc   <= align_pc(redirect_pc);
        drop_cnt <= outstanding - CW'(rsp_live);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
        if (rsp_live) begin
          if (drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
          else                rsp_pc   <= rsp_pc + PC_STEP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(imem_rsp_valid && outstanding == '0))
        else $error("riscv_ifetch: response with no request outstanding");
    end
  end

endmodule

// File: tb/tb_riscv_ifetch.sv
module tb_riscv_ifetch;
  import riscv_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_pc, dec_instr;

  always #5 clk = ~clk;

  riscv_ifetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .dec_instr      (dec_instr)
  );

  // IMEM model: each accepted request is remembered with the fetch epoch it
  // belongs to; the returned word is a hash of (address, epoch) so a stale
  // word can never match what decode is expected to see.
  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } req_t;

  req_t        pending[$];
  logic [31:0] req_log[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          lat = 1;
  int          req_cnt, dec_cnt, first_req_cyc, first_dec_cyc;
  bit          want_first;
  logic [31:0] salt, exp_req_addr, exp_dec_pc, first_pc, last_req_addr;

  function automatic logic [31:0] mix(input logic [31:0] a, input int ep);
    return ((a ^ salt) * 32'h9E37_79B1) + (32'(ep) * 32'h85EB_CA6B);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, sample settled
  // outputs, predict the handshakes, then advance the reference model.
  task automatic step(input bit rdy, input bit drdy, input bit redir,
                      input logic [31:0] rpc, input bit rsp_en);
    bit rsp_now;
    bit req_now;
    rsp_now        = 1'b0;
    req_now        = 1'b0;
    rst_n          = 1'b1;
    imem_req_ready = rdy;
    dec_ready      = drdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (rsp_en && pending.size() > 0 && pending[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mix(pending[0].addr, pending[0].ep);
      rsp_now        = 1'b1;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    if (redir) begin
      check("redir_no_req", 32'(imem_req_valid), 32'd0);
      check("redir_no_dec", 32'(dec_valid), 32'd0);
    end
    if (imem_req_valid && imem_req_ready) begin
      req_now = 1'b1;
      check("req_addr", imem_req_addr, exp_req_addr);
      check("req_cap", 32'(pending.size() < DEPTH), 32'd1);
      last_req_addr = imem_req_addr;
      req_log.push_back(imem_req_addr);
      exp_req_addr  = exp_req_addr + 32'd4;
      req_cnt++;
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (dec_valid && first_dec_cyc < 0) first_dec_cyc = cyc;
    if (dec_valid && dec_ready) begin
      if (want_first) begin
        first_pc   = dec_pc;
        want_first = 1'b0;
      end
      check("dec_pc", dec_pc, exp_dec_pc);
      check("dec_instr", dec_instr, mix(exp_dec_pc, epoch));
      exp_dec_pc = exp_dec_pc + 32'd4;
      dec_cnt++;
    end
    @(posedge clk);
    #1;
    if (rsp_now) void'(pending.pop_front());
    if (req_now) pending.push_back('{addr: last_req_addr, ep: epoch, due: cyc + lat});
    if (redir) begin
      epoch++;
      exp_req_addr = {rpc[31:2], 2'b00};
      exp_dec_pc   = {rpc[31:2], 2'b00};
      want_first   = 1'b1;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    pending.delete();
    req_log.delete();
    epoch++;
    exp_req_addr  = RESET_PC;
    exp_dec_pc    = RESET_PC;
    want_first    = 1'b0;
    req_cnt       = 0;
    dec_cnt       = 0;
    first_req_cyc = -1;
    first_dec_cyc = -1;
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_dec_pc", dec_pc, 32'd0);
    check("rst_dec_instr", dec_instr, 32'd0);
  endtask

  task automatic run_until_dec(input string tag, input logic [31:0] exp_pc);
    int n;
    n = 0;
    while (want_first && n < 30) begin
      step(1'b1, 1'b1, 1'b0, '0, 1'b1);
      n++;
    end
    check({tag, "_timeout"}, 32'(want_first), 32'd0);
    check(tag, first_pc, exp_pc);
  endtask

  initial begin
    int n;
    salt = $urandom;

    // Streaming with 1-cycle IMEM and decode always ready.
    lat = 1;
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("stream_req_cnt", 32'(req_cnt), 32'd11);
    check("first_dec_latency", 32'(first_dec_cyc - first_req_cyc), 32'd2);
    check("stream_first_req", req_log[0], 32'h0);

    // Decode stalled: exactly DEPTH requests, then drain and resume at 16.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check("stall_req_cnt", 32'(req_cnt), 32'd4);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_dec_valid", 32'(dec_valid), 32'd1);
    check("stall_dec_pc", dec_pc, 32'h0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("resume_addr", last_req_addr, 32'h10);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("drain_cnt", 32'(dec_cnt >= 8), 32'd1);

    // 3-cycle IMEM, redirect while three requests are in flight.
    lat = 3;
    do_reset();
    n = 0;
    while (pending.size() != 3 && n < 20) begin
      step(1'b1, 1'b1, 1'b0, '0, 1'b1);
      n++;
    end
    check("inflight_3", 32'(pending.size()), 32'd3);
    step(1'b1, 1'b1, 1'b1, 32'h100, 1'b1);
    run_until_dec("redir_first_pc", 32'h100);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b1);

    // Unaligned redirect target and back-to-back redirects.
    lat = 1;
    step(1'b1, 1'b1, 1'b1, 32'h203, 1'b1);
    req_log.delete();
    run_until_dec("unaligned_pc", 32'h200);
    check("unaligned_addr", req_log[0], 32'h200);
    step(1'b1, 1'b1, 1'b1, 32'h40, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h80, 1'b1);
    run_until_dec("b2b_first_pc", 32'h80);

    // Reset mid-stream with a full buffer.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check("full_dec_valid", 32'(dec_valid), 32'd1);
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("restart_addr", req_log[0], RESET_PC);
    check("restart_dec", 32'(dec_cnt > 0), 32'd1);

    // Address wrap at the top of the address space.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
    req_log.delete();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("wrap_addr0", req_log[0], 32'hFFFF_FFFC);
    check("wrap_addr1", req_log[1], 32'h0000_0000);

    // Randomised traffic: backpressure, response gaps, latency, redirects.
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) lat = $urandom_range(1, 3);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 39) == 0, $urandom,
           $urandom_range(0, 4) != 0);
    end
    dec_cnt = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("final_progress", 32'(dec_cnt > 4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
